// File: rtl/regfile_pkg.sv
// Shared register-file constants, used by the register file, the decoder and the
// write-back arbiter.
package regfile_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 8;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic {
        GrantA = 1'b0,
        GrantB = 1'b1
    } grant_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: destination reservations, operand hazard query and the
// sticky unreserved-write error flag.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_rd,
    output logic              rsv_ready,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] rf_rd,
    input  logic [ADDR_W-1:0] q_rs,
    input  logic [ADDR_W-1:0] q_rt,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              err_unreserved
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                err_q, err_d;

    always_comb begin
        rsv_ready = !rst && (!pending_q[rsv_rd] || (rf_we && rf_rd == rsv_rd));

        pending_d = pending_q;
        err_d     = err_q;
        if (rf_we) begin
            if (!pending_q[rf_rd]) begin
                err_d = 1'b1;
            end
            pending_d[rf_rd] = 1'b0;
        end
        // Applied after the clear so a same-edge re-reservation wins.
        if (rsv_valid && rsv_ready && rsv_rd != ZERO_REG) begin
            pending_d[rsv_rd] = 1'b1;
        end

        // A write landing this cycle is bypassed by the register file, so it is not a hazard.
        rs_busy = (q_rs != ZERO_REG) && pending_q[q_rs] && !(rf_we && rf_rd == q_rs);
        rt_busy = (q_rt != ZERO_REG) && pending_q[q_rt] && !(rf_we && rf_rd == q_rt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign err_unreserved = err_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: round-robin arbitration of the ALU (A) and load unit (B) onto
// the register file's single registered write port, plus the pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_rd,
    output logic              rsv_ready,
    input  logic [ADDR_W-1:0] q_rs,
    input  logic [ADDR_W-1:0] q_rt,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              err_unreserved
);

    grant_e            last_grant_q, last_grant_d;
    logic              grant_a, grant_b;
    logic              we_d;
    logic [ADDR_W-1:0] rd_d;
    logic [DATA_W-1:0] wdata_d;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (a_valid && b_valid) begin
                grant_a = (last_grant_q == GrantB);
                grant_b = !grant_a;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end

        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        rd_d         = rf_rd;
        wdata_d      = rf_wdata;
        if (grant_a) begin
            last_grant_d = GrantA;
            we_d         = (a_rd != ZERO_REG);
            rd_d         = a_rd;
            wdata_d      = a_data;
        end else if (grant_b) begin
            last_grant_d = GrantB;
            we_d         = (b_rd != ZERO_REG);
            rd_d         = b_rd;
            wdata_d      = b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GrantB;
            rf_we        <= 1'b0;
            rf_rd        <= '0;
            rf_wdata     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we        <= we_d;
            rf_rd        <= rd_d;
            rf_wdata     <= wdata_d;
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    regfile_scoreboard u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .rsv_valid      (rsv_valid),
        .rsv_rd         (rsv_rd),
        .rsv_ready      (rsv_ready),
        .rf_we          (rf_we),
        .rf_rd          (rf_rd),
        .q_rs           (q_rs),
        .q_rt           (q_rt),
        .rs_busy        (rs_busy),
        .rt_busy        (rt_busy),
        .err_unreserved (err_unreserved)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter against a behavioural model of the
// arbitration, write-port and reservation rules.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NCYC  = 600;
    localparam int DRAIN = 8;

    logic              clk, rst;
    logic              a_valid, a_ready, b_valid, b_ready;
    logic [ADDR_W-1:0] a_rd, b_rd, rf_rd, rsv_rd, q_rs, q_rt;
    logic [DATA_W-1:0] a_data, b_data, rf_wdata;
    logic              rf_we, rsv_valid, rsv_ready, rs_busy, rt_busy, err_unreserved;

    regfile_wb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_rd           (a_rd),
        .a_data         (a_data),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .b_rd           (b_rd),
        .b_data         (b_data),
        .rf_we          (rf_we),
        .rf_rd          (rf_rd),
        .rf_wdata       (rf_wdata),
        .rsv_valid      (rsv_valid),
        .rsv_rd         (rsv_rd),
        .rsv_ready      (rsv_ready),
        .q_rs           (q_rs),
        .q_rt           (q_rt),
        .rs_busy        (rs_busy),
        .rt_busy        (rt_busy),
        .err_unreserved (err_unreserved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic ga, gb, rsv, rsb, rtb, err;
    } comb_t;

    typedef struct {
        int unsigned       cyc;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    comb_t       comb_q[$];
    wr_t         wr_q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    // Reference state: which registers await a write, the sticky error, who won last,
    // and the write due to land in the register file during the next cycle.
    bit                m_pend[NUM_REGS];
    bit                m_err, m_last_a, m_cv;
    logic [ADDR_W-1:0] m_crd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] pick_rd();
        logic [ADDR_W-1:0] cand[$];
        for (int i = 0; i < NUM_REGS; i++) begin
            if (m_pend[i]) cand.push_back(ADDR_W'(i));
        end
        case ($urandom_range(0, 9))
            0:       return ZERO_REG;
            1, 2, 3: return ADDR_W'($urandom_range(0, NUM_REGS - 1));
            default: begin
                if (cand.size() > 0) return cand[$urandom_range(0, cand.size() - 1)];
                return ADDR_W'($urandom_range(0, 7));
            end
        endcase
    endfunction

    // Stimulus and model.
    initial begin
        comb_t e;
        wr_t   w;
        bit    ga, gb, a_hold, b_hold, quiet;
        int    rst_left;

        rst = 1'b1;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        rsv_valid = 1'b0; rsv_rd = '0; q_rs = '0; q_rt = '0;
        for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 1'b0;
        m_err = 1'b0; m_last_a = 1'b0; m_cv = 1'b0; m_crd = '0;
        a_hold = 1'b0; b_hold = 1'b0; rst_left = 0;
        repeat (3) @(posedge clk);

        for (int n = 0; n < NCYC + DRAIN; n++) begin
            #1;
            cyc++;
            quiet = (n >= NCYC);
            if (rst_left > 0) begin
                rst = 1'b1;
                rst_left--;
            end else begin
                rst = 1'b0;
                if (!quiet && n > 20 && $urandom_range(0, 39) == 0) begin
                    rst = 1'b1;
                    rst_left = $urandom_range(0, 2);
                end
            end

            if (!a_hold) begin
                a_valid = quiet ? 1'b0 : (n < 8 ? 1'b1 : ($urandom_range(0, 99) < 60));
                a_rd    = pick_rd();
                a_data  = DATA_W'($urandom);
            end
            if (!b_hold) begin
                b_valid = quiet ? 1'b0 : (n < 8 ? 1'b1 : ($urandom_range(0, 99) < 60));
                b_rd    = pick_rd();
                b_data  = DATA_W'($urandom);
            end
            rsv_valid = !quiet && ($urandom_range(0, 99) < 40);
            rsv_rd    = pick_rd();
            q_rs      = pick_rd();
            q_rt      = pick_rd();

            ga = 1'b0;
            gb = 1'b0;
            if (!rst) begin
                if (a_valid && b_valid) begin
                    ga = !m_last_a;
                    gb = m_last_a;
                end else begin
                    ga = a_valid;
                    gb = b_valid;
                end
            end
            e.ga  = ga;
            e.gb  = gb;
            e.rsv = !rst && (!m_pend[rsv_rd] || (m_cv && m_crd == rsv_rd));
            e.rsb = m_pend[q_rs] && !(m_cv && m_crd == q_rs);
            e.rtb = m_pend[q_rt] && !(m_cv && m_crd == q_rt);
            e.err = m_err;
            comb_q.push_back(e);

            // Effects of the coming clock edge.
            if (rst) begin
                for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 1'b0;
                m_err = 1'b0; m_last_a = 1'b0; m_cv = 1'b0;
            end else begin
                if (m_cv) begin
                    if (!m_pend[m_crd]) m_err = 1'b1;
                    m_pend[m_crd] = 1'b0;
                end
                if (rsv_valid && e.rsv && rsv_rd != ZERO_REG) m_pend[rsv_rd] = 1'b1;
                m_cv = 1'b0;
                if (ga || gb) begin
                    m_last_a = ga;
                    w.rd   = ga ? a_rd : b_rd;
                    w.data = ga ? a_data : b_data;
                    w.cyc  = cyc + 1;
                    if (w.rd != ZERO_REG) begin
                        m_cv  = 1'b1;
                        m_crd = w.rd;
                        wr_q.push_back(w);
                    end
                end
            end
            a_hold = a_valid && !ga;
            b_hold = b_valid && !gb;
            @(posedge clk);
        end

        #1;
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check("comb_queue_drained", 32'(comb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: compares DUT outputs against queued expectations mid-cycle.
    initial begin
        comb_t e;
        wr_t   w;
        forever begin
            @(negedge clk);
            if (comb_q.size() == 0) continue;
            e = comb_q.pop_front();
            check("a_ready", 32'(a_ready), 32'(e.ga));
            check("b_ready", 32'(b_ready), 32'(e.gb));
            check("rsv_ready", 32'(rsv_ready), 32'(e.rsv));
            check("rs_busy", 32'(rs_busy), 32'(e.rsb));
            check("rt_busy", 32'(rt_busy), 32'(e.rtb));
            check("err_unreserved", 32'(err_unreserved), 32'(e.err));
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                w = wr_q.pop_front();
                check("rf_we", 32'(rf_we), 32'd1);
                check("rf_rd", 32'(rf_rd), 32'(w.rd));
                check("rf_wdata", 32'(rf_wdata), 32'(w.data));
            end else begin
                check("rf_we_idle", 32'(rf_we), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
